pkt2p64: RTL and testbench
==========================

// Module: pkt2p64
// PURPOSE
//  Transmit framer: AXI network packets (64b beats) -> 66b PHY blocks, one per TX_READY cycle.
//  Inserts preamble/start, terminate and idle blocks and enforces inter-frame gap.
//  Turns underflow/abort into an error block. Feeds the TX gearbox; mirror of the 66b receive framer.
// PARAMETERS
//  IFG_BYTES  12  minimum idle bytes between packets (legal 8..24)
// PORTS
//  TX_CLK      in   1   sole clock
//  S_ARESET    in   1   synchronous reset, active-high
//  i_local_fault in 1   local RX fault; requests remote-fault signalling
//  S_VALID     in   1   packet beat valid
//  S_READY     out  1   beat accepted when S_VALID && S_READY
//  S_DATA      in   64  byte0 = [7:0]
//  S_BYTES     in   3   valid bytes on a LAST beat, 0 means 8; ignored (8) otherwise
//  S_ABORT     in   1   abandon current packet
//  S_LAST      in   1   final beat of packet
//  TX_READY    in   1   gearbox consumes TX_DATA this cycle
//  TX_DATA     out  66  {payload[63:0], sync[1:0]}; sync 2'b10 data, 2'b01 control
//  o_underflow out  1   1-cycle pulse when an error block replaces a packet
// BEHAVIOUR
//  - All state advances only when TX_READY=1; TX_DATA is registered and held while TX_READY=0.
//  - Reset: TX_DATA=IDLE, S_READY=0, o_underflow=0, state IDLE, gap satisfied.
//    Reset mid-packet: next block IDLE, no terminate.
//  - Blocks: IDLE={56'h0,8'h1e,01}; ERROR={{8{7'h1e}},8'h1e,01};
//    PREAMBLE={64'habaa_aaaa_aaaa_aa1e,01}; RFAULT={32'h0,24'h02_0000,8'h4b,01}.
//  - TERM(k), k=0..7 data bytes:
//    type 87/99/aa/b4/cc/d2/e1/ff; data bytes at [10+8k-1:10]; upper bits zero.
//  - States:
//    IDLE : emit IDLE. If S_VALID and gap satisfied: emit PREAMBLE -> DATA.
//           S_READY=0 in IDLE.
//    DATA : S_READY=TX_READY.
//           Beat !LAST: emit {S_DATA,10}.
//           LAST with S_BYTES=0: emit data block -> TERM.
//           LAST with S_BYTES=k (k>0): emit TERM(k) -> IDLE, gap from k.
//           S_VALID=0: emit ERROR, pulse o_underflow -> DROP.
//           S_ABORT=1: emit ERROR, pulse o_underflow -> DROP, or -> IDLE if the aborted beat has LAST.
//    TERM : emit TERM(0), S_READY=0 -> IDLE, gap from k=0.
//    DROP : emit IDLE, S_READY=1, discard beats.
//           Exit -> IDLE on accepted LAST beat, or on S_ABORT && !S_VALID.
//  - Gap: after TERM(k), n = max(1, ceil((IFG_BYTES-(7-k))/8)) IDLE blocks before next PREAMBLE.
//    4-bit down-counter; decrements per emitted IDLE/RFAULT block.
//  - No partial beats mid-packet; S_BYTES honoured only with S_LAST.
//  - No scrambling here; scrambler follows in the gearbox.
// CONFIGURATION
//  - P64_REMOTE_FAULT_EN defined:
//    i_local_fault is 2-FF synchronised. While high, emit RFAULT instead of IDLE in IDLE/GAP.
//    Never starts a packet while high. An in-progress packet finishes normally.
//  - Undefined: i_local_fault ignored, RFAULT never emitted.
// STRUCTURE
//  - Package p64_pkg: SYNC_DATA/SYNC_CONTROL, block-type bytes (1e,4b,78,87..ff),
//    66b IDLE/ERROR/PREAMBLE/RFAULT constants, REMOTE_FAULT 24'h02_0000, state enum.
//    Shared with the receive framer.
//  - Sub-module pkt2p64_term: combinational {S_DATA,k} -> TERM(k) block.
// TESTING
//  - 3-beat packet, last S_BYTES=4, TX_READY=1
//    -> PREAMBLE, 2 data blocks, TERM type cc with 4 bytes, then 2 IDLE before next PREAMBLE.
//  - 2-beat packet, last S_BYTES=0 -> PREAMBLE, 2 data blocks, TERM 87, then >=1 IDLE.
//  - S_VALID drops after beat 1 -> ERROR block, o_underflow 1 cycle;
//    remaining beats drained with S_READY=1; IDLE until LAST.
//  - TX_READY toggled 50% randomly -> TX_DATA stable when TX_READY=0; output stream identical to TX_READY=1 run.
//  - S_ARESET asserted mid-packet -> next TX_DATA=IDLE, S_READY=0; next packet starts with PREAMBLE.
//  - P64_REMOTE_FAULT_EN with i_local_fault=1 -> RFAULT stream, S_READY=0;
//    fault released -> IDLE, then packet proceeds.

Source files
------------

// File: rtl/p64_pkg.sv
// p64_pkg: 64b/66b framing constants shared by the transmit and receive framers.
// Sync headers, block-type bytes, fixed control blocks, FSM states and IFG helper.
package p64_pkg;

  localparam logic [1:0] SYNC_DATA    = 2'b10;
  localparam logic [1:0] SYNC_CONTROL = 2'b01;

  localparam logic [7:0] BT_IDLE   = 8'h1e;
  localparam logic [7:0] BT_RFAULT = 8'h4b;
  localparam logic [7:0] BT_START  = 8'h78;
  localparam logic [7:0] BT_TERM0  = 8'h87;
  localparam logic [7:0] BT_TERM1  = 8'h99;
  localparam logic [7:0] BT_TERM2  = 8'haa;
  localparam logic [7:0] BT_TERM3  = 8'hb4;
  localparam logic [7:0] BT_TERM4  = 8'hcc;
  localparam logic [7:0] BT_TERM5  = 8'hd2;
  localparam logic [7:0] BT_TERM6  = 8'he1;
  localparam logic [7:0] BT_TERM7  = 8'hff;

  localparam logic [23:0] REMOTE_FAULT = 24'h02_0000;

  localparam logic [65:0] BLK_IDLE =
    {56'h0, BT_IDLE, SYNC_CONTROL};
  localparam logic [65:0] BLK_ERROR =
    {{8{7'h1e}}, BT_IDLE, SYNC_CONTROL};
  localparam logic [65:0] BLK_PREAMBLE =
    {64'habaa_aaaa_aaaa_aa1e, SYNC_CONTROL};
  localparam logic [65:0] BLK_RFAULT =
    {32'h0, REMOTE_FAULT, BT_RFAULT, SYNC_CONTROL};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_TERM,
    ST_DROP
  } p64_state_e;

  // Idle blocks owed after TERM(k): the k-byte terminate already
  // carries 7-k idle bytes toward the gap; never fewer than one block.
  function automatic logic [3:0] gap_blocks(input int ifg,
                                            input logic [2:0] k);
    int num;
    num = ifg - 7 + int'(k);
    if (num <= 8) return 4'd1;
    return 4'((num + 7) / 8);
  endfunction

endpackage

// File: rtl/pkt2p64_term.sv
// pkt2p64_term: builds the 66b terminate block TERM(k) from a beat.
// Bytes 0..k-1 of the beat land after the type byte; the rest are zero.
module pkt2p64_term
  import p64_pkg::*;
(
  input  logic [55:0] data_i,
  input  logic [2:0]  k_i,
  output logic [65:0] blk_o
);

  logic [7:0]  typ;
  logic [63:0] pay;

  // Terminate type byte selected by the count of data bytes carried
  always_comb begin
    typ = BT_TERM0;
    unique case (k_i)
      3'd0: typ = BT_TERM0;
      3'd1: typ = BT_TERM1;
      3'd2: typ = BT_TERM2;
      3'd3: typ = BT_TERM3;
      3'd4: typ = BT_TERM4;
      3'd5: typ = BT_TERM5;
      3'd6: typ = BT_TERM6;
      3'd7: typ = BT_TERM7;
    endcase
  end

  // Keep the first k bytes, zero the unused upper lanes
  always_comb begin
    pay = '0;
    pay[7:0] = typ;
    for (int j = 0; j < 7; j++) begin
      if (3'(j) < k_i)
        pay[8+8*j +: 8] = data_i[8*j +: 8];
    end
  end

  assign blk_o = {pay, SYNC_CONTROL};

endmodule

// File: rtl/pkt2p64.sv
// pkt2p64: transmit framer, 64b packet beats to 66b PHY blocks.
// Optional remote-fault signalling when P64_REMOTE_FAULT_EN is defined.
module pkt2p64
  import p64_pkg::*;
#(
  parameter int IFG_BYTES = 12
) (
  input  logic        TX_CLK,
  input  logic        S_ARESET,
  input  logic        i_local_fault,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [63:0] S_DATA,
  input  logic [2:0]  S_BYTES,
  input  logic        S_ABORT,
  input  logic        S_LAST,
  input  logic        TX_READY,
  output logic [65:0] TX_DATA,
  output logic        o_underflow
);

  p64_state_e  state_q;
  logic [65:0] tx_q;
  logic        uf_q;
  logic [3:0]  gap_q;
  logic        fault;
  logic [2:0]  term_k;
  logic [65:0] term_blk;

`ifdef P64_REMOTE_FAULT_EN
  logic [1:0] flt_q;

  // Bring the asynchronous RX fault into the TX clock domain
  always_ff @(posedge TX_CLK) begin
    if (S_ARESET) flt_q <= 2'b00;
    else          flt_q <= {flt_q[0], i_local_fault};
  end

  assign fault = flt_q[1];
`else
  logic unused_fault;

  assign unused_fault = i_local_fault;
  assign fault        = 1'b0;
`endif

  assign term_k = (state_q == ST_TERM) ? 3'd0 : S_BYTES;

  pkt2p64_term u_term (
    .data_i (S_DATA[55:0]),
    .k_i    (term_k),
    .blk_o  (term_blk)
  );

  assign S_READY =
    TX_READY && (state_q == ST_DATA || state_q == ST_DROP);
  assign TX_DATA     = tx_q;
  assign o_underflow = uf_q;

  // Framing FSM: one block per TX_READY cycle, output held otherwise
  always_ff @(posedge TX_CLK) begin
    if (S_ARESET) begin
      state_q <= ST_IDLE;
      tx_q    <= BLK_IDLE;
      uf_q    <= 1'b0;
      gap_q   <= 4'd0;
    end else begin
      uf_q <= 1'b0;
      if (TX_READY) begin
        unique case (state_q)
          ST_IDLE: begin
            if (S_VALID && gap_q == 4'd0 && !fault) begin
              tx_q    <= BLK_PREAMBLE;
              state_q <= ST_DATA;
            end else begin
              tx_q <= fault ? BLK_RFAULT : BLK_IDLE;
              if (gap_q != 4'd0) gap_q <= gap_q - 4'd1;
            end
          end
          ST_DATA: begin
            if (S_ABORT) begin
              tx_q    <= BLK_ERROR;
              uf_q    <= 1'b1;
              state_q <= (S_VALID && S_LAST) ? ST_IDLE : ST_DROP;
            end else if (!S_VALID) begin
              tx_q    <= BLK_ERROR;
              uf_q    <= 1'b1;
              state_q <= ST_DROP;
            end else if (!S_LAST) begin
              tx_q <= {S_DATA, SYNC_DATA};
            end else if (S_BYTES == 3'd0) begin
              tx_q    <= {S_DATA, SYNC_DATA};
              state_q <= ST_TERM;
            end else begin
              tx_q    <= term_blk;
              state_q <= ST_IDLE;
              gap_q   <= gap_blocks(IFG_BYTES, S_BYTES);
            end
          end
          ST_TERM: begin
            tx_q    <= term_blk;
            state_q <= ST_IDLE;
            gap_q   <= gap_blocks(IFG_BYTES, 3'd0);
          end
          ST_DROP: begin
            tx_q <= BLK_IDLE;
            if ((S_VALID && S_LAST) || (S_ABORT && !S_VALID))
              state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pkt2p64.sv
// tb_pkt2p64: directed checks of the pkt2p64 transmit framer.
// Expected blocks are hand-built constants compared per emitted block.
module tb_pkt2p64;

  logic        TX_CLK = 1'b0;
  logic        S_ARESET;
  logic        i_local_fault;
  logic        S_VALID;
  logic        S_READY;
  logic [63:0] S_DATA;
  logic [2:0]  S_BYTES;
  logic        S_ABORT;
  logic        S_LAST;
  logic        TX_READY;
  logic [65:0] TX_DATA;
  logic        o_underflow;

  always #5 TX_CLK = ~TX_CLK;

  pkt2p64 #(.IFG_BYTES(12)) dut (
    .TX_CLK        (TX_CLK),
    .S_ARESET      (S_ARESET),
    .i_local_fault (i_local_fault),
    .S_VALID       (S_VALID),
    .S_READY       (S_READY),
    .S_DATA        (S_DATA),
    .S_BYTES       (S_BYTES),
    .S_ABORT       (S_ABORT),
    .S_LAST        (S_LAST),
    .TX_READY      (TX_READY),
    .TX_DATA       (TX_DATA),
    .o_underflow   (o_underflow)
  );

  localparam logic [65:0] IDLE_B = {56'h0, 8'h1e, 2'b01};
  localparam logic [65:0] ERR_B  = {{8{7'h1e}}, 8'h1e, 2'b01};
  localparam logic [65:0] PRE_B  = {64'habaa_aaaa_aaaa_aa1e, 2'b01};
  localparam logic [65:0] RF_B   = {32'h0, 24'h02_0000, 8'h4b, 2'b01};

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [2:0]  b;
    logic        l;
    logic        a;
  } beat_t;

  beat_t       fq[$];
  logic [65:0] blkq[$];
  logic [65:0] exq[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          uf_cnt = 0;
  bit          rnd = 1'b0;

  task automatic check(input string tag, input logic [65:0] got,
                       input logic [65:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [65:0] dblk(input logic [63:0] d);
    return {d, 2'b10};
  endfunction

  function automatic logic [65:0] cblk(input logic [63:0] p);
    return {p, 2'b01};
  endfunction

  task automatic beat(input logic [63:0] d, input logic [2:0] b,
                      input logic l, input logic a);
    beat_t x;
    x.v = 1'b1; x.d = d; x.b = b; x.l = l; x.a = a;
    fq.push_back(x);
  endtask

  task automatic hole();
    beat_t x;
    x.v = 1'b0; x.d = '0; x.b = '0; x.l = 1'b0; x.a = 1'b0;
    fq.push_back(x);
  endtask

  task automatic ex(input logic [65:0] b);
    exq.push_back(b);
  endtask

  task automatic cycle();
    logic        acc;
    logic        rdy;
    logic [65:0] prev;
    @(negedge TX_CLK);
    TX_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (fq.size() > 0 && fq[0].v) begin
      S_VALID = 1'b1;
      S_DATA  = fq[0].d;
      S_BYTES = fq[0].b;
      S_LAST  = fq[0].l;
      S_ABORT = fq[0].a;
    end else begin
      S_VALID = 1'b0;
      S_DATA  = '0;
      S_BYTES = '0;
      S_LAST  = 1'b0;
      S_ABORT = 1'b0;
    end
    #1;
    acc  = S_VALID && S_READY;
    rdy  = TX_READY;
    prev = TX_DATA;
    @(posedge TX_CLK);
    #1;
    if (rdy) blkq.push_back(TX_DATA);
    else     check("hold", TX_DATA, prev);
    if (o_underflow) uf_cnt++;
    if (fq.size() > 0 && (!fq[0].v || acc)) fq.delete(0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, 66'(blkq.size() >= exq.size()), 66'(1));
    for (int i = 0; i < exq.size(); i++) begin
      if (i < blkq.size())
        check($sformatf("%s[%0d]", tag, i), blkq[i], exq[i]);
    end
  endtask

  task automatic load_two_pkts();
    beat(64'h0706_0504_0302_0100, 3'd0, 1'b0, 1'b0);
    beat(64'h0f0e_0d0c_0b0a_0908, 3'd0, 1'b0, 1'b0);
    beat(64'h1716_1514_1312_1110, 3'd4, 1'b1, 1'b0);
    beat(64'hdead_beef_0123_4567, 3'd0, 1'b0, 1'b0);
    beat(64'hfeed_face_89ab_cdef, 3'd0, 1'b0, 1'b0);
    beat(64'h2726_2524_2322_2120, 3'd4, 1'b1, 1'b0);
    exq.delete();
    ex(PRE_B);
    ex(dblk(64'h0706_0504_0302_0100));
    ex(dblk(64'h0f0e_0d0c_0b0a_0908));
    ex(cblk(64'h0000_0013_1211_10cc));
    ex(IDLE_B);
    ex(IDLE_B);
    ex(PRE_B);
    ex(dblk(64'hdead_beef_0123_4567));
    ex(dblk(64'hfeed_face_89ab_cdef));
    ex(cblk(64'h0000_0023_2221_20cc));
    ex(IDLE_B);
    ex(IDLE_B);
  endtask

  initial begin
    S_ARESET      = 1'b1;
    i_local_fault = 1'b0;
    S_VALID       = 1'b0;
    S_DATA        = '0;
    S_BYTES       = '0;
    S_ABORT       = 1'b0;
    S_LAST        = 1'b0;
    TX_READY      = 1'b1;
    repeat (3) @(posedge TX_CLK);
    #1;
    check("rst_tx", TX_DATA, IDLE_B);
    check("rst_rdy", 66'(S_READY), 66'(0));
    check("rst_uf", 66'(o_underflow), 66'(0));
    @(negedge TX_CLK);
    S_ARESET = 1'b0;

    // back-to-back 3-beat packets, k=4
    blkq.delete();
    load_two_pkts();
    run(14);
    cmp_stream("t1");

    // S_BYTES=0 then a one-beat k=7 packet
    blkq.delete();
    exq.delete();
    beat(64'h1111_2222_3333_4444, 3'd0, 1'b0, 1'b0);
    beat(64'h5555_6666_7777_8888, 3'd0, 1'b1, 1'b0);
    beat(64'h0123_4567_89ab_cdef, 3'd7, 1'b1, 1'b0);
    ex(PRE_B);
    ex(dblk(64'h1111_2222_3333_4444));
    ex(dblk(64'h5555_6666_7777_8888));
    ex(cblk(64'h0000_0000_0000_0087));
    ex(IDLE_B);
    ex(PRE_B);
    ex(cblk(64'h2345_6789_abcd_efff));
    ex(IDLE_B);
    ex(IDLE_B);
    run(10);
    cmp_stream("t2");

    // underflow mid-packet, drain, then a k=1 packet
    blkq.delete();
    exq.delete();
    uf_cnt = 0;
    beat(64'haaaa_bbbb_cccc_dddd, 3'd0, 1'b0, 1'b0);
    hole();
    beat(64'h1234_5678_9abc_def0, 3'd0, 1'b0, 1'b0);
    beat(64'h0fed_cba9_8765_4321, 3'd3, 1'b1, 1'b0);
    beat(64'h0000_0000_0000_00a5, 3'd1, 1'b1, 1'b0);
    ex(PRE_B);
    ex(dblk(64'haaaa_bbbb_cccc_dddd));
    ex(ERR_B);
    ex(IDLE_B);
    ex(IDLE_B);
    ex(PRE_B);
    ex(cblk(64'h0000_0000_0000_a599));
    ex(IDLE_B);
    ex(IDLE_B);
    run(10);
    cmp_stream("t3");
    check("t3_uf_pulses", 66'(uf_cnt), 66'(1));
    check("t3_drained", 66'(fq.size()), 66'(0));

    // random TX_READY stalls, same stream as t1
    blkq.delete();
    rnd = 1'b1;
    load_two_pkts();
    run(80);
    rnd = 1'b0;
    cmp_stream("t4");
    run(4);

    // reset in the middle of a packet
    blkq.delete();
    beat(64'h0706_0504_0302_0100, 3'd0, 1'b0, 1'b0);
    beat(64'h0f0e_0d0c_0b0a_0908, 3'd0, 1'b0, 1'b0);
    beat(64'h1716_1514_1312_1110, 3'd4, 1'b1, 1'b0);
    run(3);
    fq.delete();
    @(negedge TX_CLK);
    S_ARESET = 1'b1;
    S_VALID  = 1'b0;
    S_LAST   = 1'b0;
    TX_READY = 1'b1;
    @(posedge TX_CLK);
    #1;
    check("t5_rst_tx", TX_DATA, IDLE_B);
    check("t5_rst_rdy", 66'(S_READY), 66'(0));
    @(negedge TX_CLK);
    S_ARESET = 1'b0;
    blkq.delete();
    exq.delete();
    beat(64'hffee_ddcc_bbaa_9988, 3'd2, 1'b1, 1'b0);
    ex(PRE_B);
    ex(cblk(64'h0000_0000_0099_88aa));
    ex(IDLE_B);
    ex(IDLE_B);
    run(5);
    cmp_stream("t5");

    // abort on a LAST beat returns straight to IDLE
    blkq.delete();
    exq.delete();
    uf_cnt = 0;
    beat(64'h0000_0000_0000_0001, 3'd0, 1'b0, 1'b0);
    beat(64'h0000_0000_0000_0002, 3'd0, 1'b1, 1'b1);
    beat(64'h0000_0000_00c3_b2a1, 3'd3, 1'b1, 1'b0);
    ex(PRE_B);
    ex(dblk(64'h0000_0000_0000_0001));
    ex(ERR_B);
    ex(PRE_B);
    ex(cblk(64'h0000_0000_c3b2_a1b4));
    ex(IDLE_B);
    ex(IDLE_B);
    run(8);
    cmp_stream("t6");
    check("t6_uf_pulses", 66'(uf_cnt), 66'(1));

`ifdef P64_REMOTE_FAULT_EN
    // remote fault holds off a waiting packet
    blkq.delete();
    exq.delete();
    i_local_fault = 1'b1;
    run(4);
    check("rf_sync0", blkq[0], IDLE_B);
    check("rf_sync1", blkq[1], IDLE_B);
    check("rf_on", blkq[3], RF_B);
    blkq.delete();
    beat(64'h0605_0403_0201_0000, 3'd5, 1'b1, 1'b0);
    run(3);
    check("rf_hold0", blkq[0], RF_B);
    check("rf_hold2", blkq[2], RF_B);
    check("rf_pending", 66'(fq.size()), 66'(1));
    check("rf_rdy", 66'(S_READY), 66'(0));
    blkq.delete();
    i_local_fault = 1'b0;
    ex(RF_B);
    ex(RF_B);
    ex(PRE_B);
    ex(cblk(64'h0000_0302_0100_00d2));
    run(6);
    cmp_stream("rf_rel");
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
